// File: rtl/etc_multilane_reporter.sv
`default_nettype none
// ============================================================================
// Module   : etc_multilane_reporter
// Purpose  : Captures one pending speed record per non-stop ETC lane and
//            arbitrates between lanes round-robin. Each record is packed into
//            a fixed-length byte frame, the bytes are queued in a small FIFO,
//            and they are sent out on an 8N1 UART line.
// Options  : ETC_CHECKSUM_EN - when defined, each frame ends with an XOR
//            checksum byte (5-byte frames); otherwise frames are 4 bytes.
// Revision : 1.0 - initial release
// ============================================================================
module etc_multilane_reporter #(
   parameter int LANES        = 4,
   parameter int WIDTH_SPEED  = 14,
   parameter int DEPTH        = 8,
   parameter int SYS_FREQ     = 500000,
   parameter int BAUD_RATE    = 11500,
   parameter int CLKS_PER_BIT = SYS_FREQ / BAUD_RATE
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [LANES-1:0]             done,
   input  logic [LANES*WIDTH_SPEED-1:0] speed,
   output logic [LANES-1:0]             overflow,
   output logic                         busy,
   output logic                         serial_data_out
);

`ifdef ETC_CHECKSUM_EN
   localparam int FRAME_LEN = 5;
`else
   localparam int FRAME_LEN = 4;
`endif

   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT + 1);

   localparam logic [AW:0]    MAX_FILL  = (AW+1)'(DEPTH - FRAME_LEN);
   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [LW:0]    LANES_X   = (LW+1)'(LANES);
   localparam logic [7:0]     SYNC_BYTE = 8'hA5;

   // ------------------------------------------------------------------------
   // State types
   // ------------------------------------------------------------------------
   typedef enum logic [2:0] {
      P_IDLE = 3'd0,
      P_SYNC = 3'd1,
      P_LANE = 3'd2,
      P_SPDH = 3'd3,
`ifdef ETC_CHECKSUM_EN
      P_SPDL = 3'd4,
      P_CSUM = 3'd5
`else
      P_SPDL = 3'd4
`endif
   } pk_state_t;

   typedef enum logic [1:0] {
      U_IDLE  = 2'd0,
      U_START = 2'd1,
      U_DATA  = 2'd2,
      U_STOP  = 2'd3
   } u_state_t;

   // ------------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------------
   logic [LANES-1:0]       pending;
   logic [WIDTH_SPEED-1:0] cap [LANES];
   logic [LANES-1:0]       take;
   logic [LANES-1:0]       gnt_onehot;

   logic [LW-1:0]          rr;
   logic [LW-1:0]          gnt_lane;
   logic [LW:0]            cand;
   logic [LW:0]            rr_inc;
   logic                   any_pending;
   logic                   grant;

   pk_state_t              pk_state;
   pk_state_t              pk_next;
   logic [LW-1:0]          pk_lane;
   logic [15:0]            pk_speed;
   logic [7:0]             lane_byte;
   logic                   wr_en;
   logic [7:0]             wr_data;

   logic [7:0]             mem [DEPTH];
   logic [AW:0]            wr_ptr;
   logic [AW:0]            rd_ptr;
   logic [AW:0]            fill;
   logic                   empty;
   logic                   full;
   logic                   fill_ok;
   logic [7:0]             rd_data;

   u_state_t               u_state;
   u_state_t               u_next;
   logic                   rd_en;
   logic                   baud_done;
   logic [BW-1:0]          baud;
   logic [2:0]             bitn;
   logic [7:0]             shreg;
   logic                   line;

   // ------------------------------------------------------------------------
   // Per-lane capture qualifiers
   // ------------------------------------------------------------------------
   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         assign gnt_onehot[i] = grant && (gnt_lane == LW'(i));
         // A lane being granted this cycle frees its slot, so a coincident
         // done refills it instead of counting as an overflow.
         assign take[i]       = done[i] && enable && (!pending[i] || gnt_onehot[i]);
      end
   endgenerate

   // Capture lane results, track pending records and sticky overflow flags
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (take[i]) begin
            cap[i] <= speed[i*WIDTH_SPEED +: WIDTH_SPEED];
         end
      end
      if (reset) begin
         pending  <= '0;
         overflow <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (take[i]) begin
               pending[i] <= 1'b1;
            end else if (gnt_onehot[i]) begin
               pending[i] <= 1'b0;
            end else if (done[i] && enable && pending[i]) begin
               overflow[i] <= 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Round-robin arbiter: first pending lane at or above rr, with wrap
   // ------------------------------------------------------------------------
   // Search downward so the lowest offset from rr is assigned last and wins
   always_comb begin
      any_pending = 1'b0;
      gnt_lane    = '0;
      cand        = '0;
      for (int k = LANES - 1; k >= 0; k--) begin
         cand = {1'b0, rr} + (LW+1)'(k);
         if (cand >= LANES_X) begin
            cand = cand - LANES_X;
         end
         if (pending[cand[LW-1:0]]) begin
            any_pending = 1'b1;
            gnt_lane    = cand[LW-1:0];
         end
      end
   end

   // Frames are only started when the whole frame fits, so they never split
   assign fill    = wr_ptr - rd_ptr;
   assign fill_ok = (fill <= MAX_FILL);
   assign grant   = (pk_state == P_IDLE) && any_pending && fill_ok;
   assign rr_inc  = {1'b0, gnt_lane} + (LW+1)'(1);

   // Latch the granted record and advance the round-robin pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         rr       <= '0;
         pk_lane  <= '0;
         pk_speed <= '0;
      end else if (grant) begin
         rr       <= (rr_inc == LANES_X) ? '0 : rr_inc[LW-1:0];
         pk_lane  <= gnt_lane;
         pk_speed <= 16'(cap[gnt_lane]);
      end
   end

   // ------------------------------------------------------------------------
   // Packer FSM
   // ------------------------------------------------------------------------
   assign lane_byte = 8'(pk_lane);

   // Packer state register
   always_ff @(posedge clk) begin
      if (reset) begin
         pk_state <= P_IDLE;
      end else begin
         pk_state <= pk_next;
      end
   end

   // Packer next state and the byte written in each state
   always_comb begin
      pk_next = pk_state;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      case (pk_state)
         P_IDLE: begin
            if (grant) begin
               pk_next = P_SYNC;
            end
         end
         P_SYNC: begin
            wr_en   = 1'b1;
            wr_data = SYNC_BYTE;
            pk_next = P_LANE;
         end
         P_LANE: begin
            wr_en   = 1'b1;
            wr_data = lane_byte;
            pk_next = P_SPDH;
         end
         P_SPDH: begin
            wr_en   = 1'b1;
            wr_data = pk_speed[15:8];
            pk_next = P_SPDL;
         end
         P_SPDL: begin
            wr_en   = 1'b1;
            wr_data = pk_speed[7:0];
`ifdef ETC_CHECKSUM_EN
            pk_next = P_CSUM;
`else
            pk_next = P_IDLE;
`endif
         end
`ifdef ETC_CHECKSUM_EN
         P_CSUM: begin
            wr_en   = 1'b1;
            wr_data = lane_byte ^ pk_speed[15:8] ^ pk_speed[7:0];
            pk_next = P_IDLE;
         end
`endif
         default: begin
            pk_next = P_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Byte FIFO (binary pointers with an extra wrap bit)
   // ------------------------------------------------------------------------
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // FIFO storage write port
   always_ff @(posedge clk) begin
      if (wr_en && !full) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   // FIFO pointers; simultaneous write and read are both honoured
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en && !full) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // UART transmitter FSM (8N1)
   // ------------------------------------------------------------------------
   assign baud_done = (baud == BAUD_LAST);

   // UART state register
   always_ff @(posedge clk) begin
      if (reset) begin
         u_state <= U_IDLE;
      end else begin
         u_state <= u_next;
      end
   end

   // UART next state and FIFO pop
   always_comb begin
      u_next = u_state;
      rd_en  = 1'b0;
      case (u_state)
         U_IDLE: begin
            if (!empty) begin
               rd_en  = 1'b1;
               u_next = U_START;
            end
         end
         U_START: begin
            if (baud_done) begin
               u_next = U_DATA;
            end
         end
         U_DATA: begin
            if (baud_done && (bitn == 3'd7)) begin
               u_next = U_STOP;
            end
         end
         U_STOP: begin
            if (baud_done) begin
               u_next = U_IDLE;
            end
         end
         default: begin
            u_next = U_IDLE;
         end
      endcase
   end

   // UART datapath: baud/bit counters, shift register and line driver
   always_ff @(posedge clk) begin
      if (reset) begin
         baud  <= '0;
         bitn  <= '0;
         shreg <= '0;
         line  <= 1'b1;
      end else begin
         case (u_state)
            U_IDLE: begin
               baud <= '0;
               bitn <= '0;
               if (rd_en) begin
                  shreg <= rd_data;
                  line  <= 1'b0;
               end
            end
            U_START: begin
               if (baud_done) begin
                  baud  <= '0;
                  line  <= shreg[0];
                  shreg <= {1'b0, shreg[7:1]};
               end else begin
                  baud <= baud + BW'(1);
               end
            end
            U_DATA: begin
               if (baud_done) begin
                  baud <= '0;
                  if (bitn == 3'd7) begin
                     line <= 1'b1;
                  end else begin
                     bitn  <= bitn + 3'd1;
                     line  <= shreg[0];
                     shreg <= {1'b0, shreg[7:1]};
                  end
               end else begin
                  baud <= baud + BW'(1);
               end
            end
            U_STOP: begin
               if (baud_done) begin
                  baud <= '0;
               end else begin
                  baud <= baud + BW'(1);
               end
            end
            default: begin
               line <= 1'b1;
            end
         endcase
      end
   end

   assign serial_data_out = line;

   // Registered activity flag, one cycle behind the internal state
   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= 1'b0;
      end else begin
         busy <= (|pending) || (pk_state != P_IDLE) || !empty || (u_state != U_IDLE);
      end
   end

endmodule
`default_nettype wire
